// File: rtl/syn_current_integrator.sv
// Exponentially decaying current-based synapse: one shared saturating adder walks the
// latched spike vector once per tick. Optional build macro: SYN_ZERO_SKIP_EN (visit set bits only).
module syn_current_integrator #(
  parameter int N_IN  = 8,
  parameter int W     = 16,
  parameter int Q     = 8,
  parameter int TAU_A = 230,  // FX(0.90) in Q8
  parameter int AW    = (N_IN > 1) ? $clog2(N_IN) : 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            tick,
  input  logic [N_IN-1:0] spikes_in,
  input  logic            wr_en,
  input  logic [AW-1:0]   wr_addr,
  input  logic [W-1:0]    wr_data,
  output logic            busy,
  output logic [W-1:0]    i_out,
  output logic            i_valid,
  output logic            overrun
);
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_DECAY = 2'd1;
  localparam logic [1:0] S_ACCUM = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic signed [W-1:0]   FX_MAX = {1'b0, {(W-1){1'b1}}};
  localparam logic signed [W-1:0]   FX_MIN = {1'b1, {(W-1){1'b0}}};
  localparam logic signed [2*W-1:0] MAX2   = {{W{1'b0}}, FX_MAX};
  localparam logic signed [2*W-1:0] MIN2   = {{W{1'b1}}, FX_MIN};
  localparam logic signed [W-1:0]   TAU_W  = W'(TAU_A);

  logic [1:0]            state;
  logic [N_IN-1:0]       spk_q;
  logic signed [W-1:0]   acc;
  logic signed [W-1:0]   weight [N_IN];
  logic [AW-1:0]         rd_idx;
  logic                  add_en;
  logic                  addr_ok;

  logic signed [2*W-1:0] prod, prod_sh;
  logic signed [W-1:0]   decay_sat;
  logic signed [W-1:0]   w_rd;
  logic signed [W:0]     sum;
  logic signed [W-1:0]   sum_sat;

  assign busy = (state != S_IDLE);

  generate
    if ((2 ** AW) == N_IN) begin : g_addr_full
      assign addr_ok = 1'b1;
    end else begin : g_addr_cmp
      localparam logic [AW:0] N_IN_V = (AW+1)'(N_IN);
      assign addr_ok = ({1'b0, wr_addr} < N_IN_V);
    end
  endgenerate

  // Full-width product, floor shift, then clamp back into W bits.
  assign prod      = TAU_W * $signed(i_out);
  assign prod_sh   = prod >>> Q;
  assign decay_sat = (prod_sh > MAX2) ? FX_MAX :
                     (prod_sh < MIN2) ? FX_MIN : prod_sh[W-1:0];

  assign w_rd    = weight[rd_idx];
  assign sum     = {acc[W-1], acc} + {w_rd[W-1], w_rd};
  assign sum_sat = (sum[W] != sum[W-1]) ? (sum[W] ? FX_MIN : FX_MAX) : sum[W-1:0];

`ifdef SYN_ZERO_SKIP_EN
  logic [AW-1:0]   pick;
  logic [N_IN-1:0] spk_rest;

  // Lowest set bit wins; each visited bit is cleared so the walk ends when spk_q empties.
  always_comb begin
    pick = '0;
    for (int i = N_IN - 1; i >= 0; i--)
      if (spk_q[i]) pick = AW'(i);
  end
  assign spk_rest = spk_q & ~(N_IN'(1) << pick);
  assign rd_idx   = pick;
  assign add_en   = 1'b1;
`else
  localparam logic [AW-1:0] LAST = AW'(N_IN - 1);
  logic [AW-1:0] idx;
  assign rd_idx = idx;
  assign add_en = spk_q[idx];
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      spk_q   <= '0;
      acc     <= '0;
      i_out   <= '0;
      i_valid <= 1'b0;
      overrun <= 1'b0;
`ifndef SYN_ZERO_SKIP_EN
      idx     <= '0;
`endif
      for (int k = 0; k < N_IN; k++) weight[k] <= '0;
    end else begin
      i_valid <= 1'b0;
      if (tick && busy) overrun <= 1'b1;
      // ACCUM reads the pre-write value when a write hits the same index.
      if (wr_en && addr_ok) weight[wr_addr] <= wr_data;
      case (state)
        S_IDLE: begin
          if (tick) begin
            spk_q <= spikes_in;
`ifndef SYN_ZERO_SKIP_EN
            idx   <= '0;
`endif
            state <= S_DECAY;
          end
        end
        S_DECAY: begin
          acc <= decay_sat;
`ifdef SYN_ZERO_SKIP_EN
          state <= (spk_q == '0) ? S_DONE : S_ACCUM;
`else
          state <= S_ACCUM;
`endif
        end
        S_ACCUM: begin
          if (add_en) acc <= sum_sat;
`ifdef SYN_ZERO_SKIP_EN
          spk_q <= spk_rest;
          if (spk_rest == '0) state <= S_DONE;
`else
          idx <= idx + 1'b1;
          if (idx == LAST) state <= S_DONE;
`endif
        end
        S_DONE: begin
          i_out   <= acc;
          i_valid <= 1'b1;
          state   <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: doc/syn_current_integrator.md
Name: syn_current_integrator

Overview:
- Upstream stage of `lif_neuron`. Converts a vector of presynaptic spikes into the signed fixed-point synaptic current that drives the neuron's `i_in`.
- Implements an exponentially decaying, current-based synapse with a programmable per-input weight register file.
- A single shared adder is time-multiplexed across inputs by a small FSM, once per `tick`.
- Uses the `W`/`Q` Q-format, `FX()`, `FX_MAX`/`FX_MIN` and saturation semantics of `lif_pkg.vh`.

Parameters:
- N_IN, 8, number of presynaptic inputs (≥1).
- TAU_A, `FX(0.90)`, signed W-bit decay factor applied to the held current each tick (0 ≤ TAU_A < `FX(1.0)`).
- AW, clog2(N_IN) (min 1), weight address width.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active-high.
- tick  in  1  start-of-update strobe; honoured only in IDLE.
- spikes_in  in  N_IN  presynaptic spike vector; sampled in the cycle `tick` is accepted.
- wr_en  in  1  weight write strobe.
- wr_addr  in  AW  weight index; writes with wr_addr ≥ N_IN are dropped.
- wr_data  in  W  signed Q-format weight.
- busy  out  1  high from DECAY through DONE inclusive.
- i_out  out  W  signed synaptic current; held between updates; connects to `lif_neuron.i_in`.
- i_valid  out  1  one-cycle pulse when i_out takes a new value.
- overrun  out  1  sticky; set when tick=1 while busy=1; cleared only by rst.

Behaviour:
- Reset (rst=1 at a clk edge), taking priority over everything:
  - State ← IDLE.
  - i_out, accumulator, all weights, latched spikes ← 0.
  - busy, i_valid, overrun ← 0.
  - Applies mid-update too: the update is abandoned and no i_valid is issued.
- FSM states: IDLE, DECAY, ACCUM, DONE.
- IDLE: on tick=1 latch spikes_in into spk_q, index ← 0, go to DECAY.
- DECAY (1 cycle):
  - acc ← sat_W((TAU_A × i_out) >>> Q).
  - Full 2W-bit signed product; arithmetic shift (truncate toward −inf); saturate to [FX_MIN, FX_MAX].
  - Go to ACCUM.
- ACCUM (exactly N_IN cycles, index 0..N_IN−1 ascending):
  - If spk_q[index]: acc ← sat_W(acc + weight[index]), computed at W+1 bits then saturated.
  - Saturation is applied after each addition, so the result is order-dependent by design.
  - After index N_IN−1, go to DONE.
- DONE (1 cycle): i_out ← acc, i_valid=1 for this cycle only, go to IDLE.
- Latency:
  - tick sampled at edge 0; i_out/i_valid update at edge N_IN+2.
  - Next tick is accepted at edge N_IN+3 at the earliest, giving throughput of one update per N_IN+3 cycles.
- Tick while busy: ignored (spk_q unchanged); overrun ← 1.
- Weight writes:
  - Accepted in any state, taking effect at the next edge.
  - If ACCUM reads weight[k] in the same cycle wr_en targets k, the old value is used.
- spikes_in changes after acceptance have no effect on the update in progress.
- All-zero spike vector: pure decay; i_out = sat(TAU_A×i_out >>> Q).

Optional Feature:
- Macro `SYN_ZERO_SKIP_EN`.
- When defined:
  - ACCUM visits only set bits of spk_q, lowest index first, via a priority encoder that clears each visited bit.
  - Latency becomes k+2 cycles, where k = popcount(spk_q).
  - With k=0, DECAY goes directly to DONE (latency 2).
  - Results are bit-identical to the non-skip build.
- When undefined: fixed N_IN-cycle ACCUM as specified above.

Test Plan:
- Weights 0,1 = `FX(0.35)`, i_out=0, tick with spikes_in=8'b00000011 → i_out=`FX(0.70)` ±1 LSB; i_valid single pulse exactly 10 cycles after tick (N_IN=8); busy high for cycles 1..10.
- Follow-up tick with spikes_in=0 → i_out = (`FX(0.90)`×prev)>>>Q, i.e. `FX(0.63)` ±1 LSB; repeat 50 ticks → monotonic decay to 0, never negative.
- Saturation:
  - All weights = `FX_MAX`, spikes=8'hFF → i_out=`FX_MAX`.
  - Then all weights = `FX_MIN`, spikes=8'hFF → i_out=`FX_MIN`.
  - No wrap in either case.
- Mixed sign: weight0=`FX(0.5)`, weight1=−`FX(0.25)`, spikes=8'b11 → i_out=`FX(0.25)`; drive i_out into `lif_neuron` and check its v_mem against the reference model.
- tick reasserted 3 cycles after acceptance → ignored, overrun=1 and stays set, result equals the single-tick value; wr_en to the index being read in ACCUM → old weight used, new weight used on the next tick.
- rst pulsed during ACCUM → next cycle busy=0, i_out=0, overrun=0, no i_valid; a subsequent tick with spikes=8'hFF gives i_out=0 because all weights were reset; with `SYN_ZERO_SKIP_EN`, spikes=8'b00100000 → i_valid 3 cycles after tick.
